// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the 5-stage CPU inter-stage pipeline registers:
// depth selectors, per-stage payload widths and occupancy encodings.
package cpu_pipe_pkg;

    localparam int PIPE_DEPTH_REG  = 1;
    localparam int PIPE_DEPTH_SKID = 2;

    // Payload widths as packed by each stage
    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 160;
    localparam int EX_MEM_W = 104;
    localparam int MEM_WB_W = 72;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Two-entry skid buffer controller: tracks occupancy and steers head/skid loads.
// Upstream allowin is derived from the state register only.
module pipe_skid_ctrl
    import cpu_pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    output logic       h_from_in,
    output logic       h_from_skid,
    output logic       s_load,
    output logic [1:0] occupancy,
    output logic       allowin
);

    occ_e state_r;
    occ_e state_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= OCC_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and load steering; flush overrides any push or pop
    always_comb begin
        state_s     = state_r;
        h_from_in   = 1'b0;
        h_from_skid = 1'b0;
        s_load      = 1'b0;
        if (flush) begin
            state_s = OCC_EMPTY;
        end else begin
            case (state_r)
                OCC_EMPTY: begin
                    if (push) begin
                        h_from_in = 1'b1;
                        state_s   = OCC_ONE;
                    end else begin
                        state_s   = OCC_EMPTY;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        h_from_in = 1'b1;
                        state_s   = OCC_ONE;
                    end else if (push) begin
                        s_load    = 1'b1;
                        state_s   = OCC_FULL;
                    end else if (pop) begin
                        state_s   = OCC_EMPTY;
                    end else begin
                        state_s   = OCC_ONE;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        h_from_skid = 1'b1;
                        state_s     = OCC_ONE;
                    end else begin
                        state_s     = OCC_FULL;
                    end
                end
                default: begin
                    state_s = OCC_EMPTY;
                end
            endcase
        end
    end

    assign occupancy = state_r;
    assign allowin   = (occupancy < 2'd2);

endmodule

// File: rtl/pipe_stage_buf.sv
// Generic inter-stage pipeline register with valid/allowin handshake, ready_go
// stall qualifier and synchronous flush; DEPTH=1 plain register, DEPTH=2 skid buffer.
module pipe_stage_buf
    import cpu_pipe_pkg::*;
#(
    parameter int                DATA_W    = 64,
    parameter int                DEPTH     = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_allowin,
    input  logic [DATA_W-1:0] in_data,
    input  logic              ready_go,
    input  logic              out_allowin,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    logic head_valid_s;
    logic push_s;
    logic pop_s;

    assign head_valid_s = (occupancy != 2'd0);
    assign out_valid    = head_valid_s & ready_go;
    assign pop_s        = out_valid & out_allowin;
    assign push_s       = in_valid & in_allowin & ~flush;

    generate
        if (DEPTH == PIPE_DEPTH_REG) begin : g_reg
            logic              valid_r;
            logic [DATA_W-1:0] head_r;

            // Single entry: load on push, retire on pop; stale data kept when empty
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    valid_r <= 1'b0;
                    head_r  <= CLEAR_VAL;
                end else if (push_s) begin
                    valid_r <= 1'b1;
                    head_r  <= in_data;
                end else if (pop_s) begin
                    valid_r <= 1'b0;
                end else begin
                    valid_r <= valid_r;
                end
            end

            assign in_allowin = ~valid_r | (ready_go & out_allowin);
            assign occupancy  = {1'b0, valid_r};
            assign out_data   = head_r;
        end else if (DEPTH == PIPE_DEPTH_SKID) begin : g_skid
            logic              h_from_in_s;
            logic              h_from_skid_s;
            logic              s_load_s;
            logic [DATA_W-1:0] head_r;
            logic [DATA_W-1:0] skid_r;

            pipe_skid_ctrl u_ctrl (
                .clk         (clk),
                .rst         (rst),
                .flush       (flush),
                .push        (push_s),
                .pop         (pop_s),
                .h_from_in   (h_from_in_s),
                .h_from_skid (h_from_skid_s),
                .s_load      (s_load_s),
                .occupancy   (occupancy),
                .allowin     (in_allowin)
            );

            // Head and skid payload storage, steered by the controller
            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    head_r <= CLEAR_VAL;
                    skid_r <= CLEAR_VAL;
                end else begin
                    if (h_from_in_s) begin
                        head_r <= in_data;
                    end else if (h_from_skid_s) begin
                        head_r <= skid_r;
                    end else begin
                        head_r <= head_r;
                    end
                    if (s_load_s) begin
                        skid_r <= in_data;
                    end else begin
                        skid_r <= skid_r;
                    end
                end
            end

            assign out_data = head_r;
        end else begin : g_bad_depth
            $error("pipe_stage_buf: DEPTH must be 1 or 2");
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboarded bench for pipe_stage_buf, DEPTH=1 and DEPTH=2 side by side on shared
// stimulus; a FIFO reference model predicts handshake, occupancy and payload order.
module tb_pipe_stage_buf;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         ready_go;
    logic         out_allowin;
    logic         flush;

    logic         in_allowin_w [2];
    logic         out_valid_w  [2];
    logic [W-1:0] out_data_w   [2];
    logic [1:0]   occ_w        [2];

    int checks = 0;
    int errors = 0;

    // Reference model: per-instance FIFO contents, count and last delivered value
    logic [W-1:0] mq   [2][4];
    int           cnt  [2];
    logic [W-1:0] last [2];
    bit           known = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(W), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_allowin(in_allowin_w[0]),
        .in_data(in_data), .ready_go(ready_go), .out_allowin(out_allowin),
        .out_valid(out_valid_w[0]), .out_data(out_data_w[0]), .flush(flush),
        .occupancy(occ_w[0])
    );

    pipe_stage_buf #(.DATA_W(W), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_allowin(in_allowin_w[1]),
        .in_data(in_data), .ready_go(ready_go), .out_allowin(out_allowin),
        .out_valid(out_valid_w[1]), .out_data(out_data_w[1]), .flush(flush),
        .occupancy(occ_w[1])
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT state against the model, then advance the model to the next edge
    always @(negedge clk) begin
        int depth;
        bit m_allow;
        bit m_push;
        bit m_pop;
        logic a_allow;
        for (int i = 0; i < 2; i++) begin
            depth   = i + 1;
            m_allow = (depth == 2) ? (cnt[i] < 2) : ((cnt[i] == 0) || (ready_go && out_allowin));
            if (known) begin
                chk($sformatf("in_allowin[d%0d]", depth), 32'(in_allowin_w[i]), 32'(m_allow));
                chk($sformatf("out_valid[d%0d]", depth), 32'(out_valid_w[i]),
                    32'((cnt[i] > 0) && ready_go));
                chk($sformatf("occupancy[d%0d]", depth), 32'(occ_w[i]), 32'(cnt[i]));
                chk($sformatf("occ_bound[d%0d]", depth), 32'(int'(occ_w[i]) <= depth), 32'd1);
                chk($sformatf("out_data[d%0d]", depth), out_data_w[i],
                    (cnt[i] > 0) ? mq[i][0] : last[i]);
                if (out_valid_w[i] && out_allowin) begin
                    if (cnt[i] == 0) begin
                        chk($sformatf("pop_when_empty[d%0d]", depth), 32'd1, 32'd0);
                    end else begin
                        chk($sformatf("pop_order[d%0d]", depth), out_data_w[i], mq[i][0]);
                    end
                end
            end
            if (rst || flush) begin
                cnt[i]  = 0;
                last[i] = '0;
            end else if (known) begin
                m_pop  = (cnt[i] > 0) && ready_go && out_allowin;
                m_push = in_valid && m_allow;
                if (m_pop) begin
                    last[i]  = mq[i][0];
                    mq[i][0] = mq[i][1];
                    mq[i][1] = mq[i][2];
                    cnt[i]--;
                end
                if (m_push) begin
                    mq[i][cnt[i]] = in_data;
                    cnt[i]++;
                end
            end
        end
        if (rst) begin
            known = 1'b1;
        end
        // DEPTH=2 allowin must not react to out_allowin or ready_go within a cycle
        if (known && !rst) begin
            a_allow     = in_allowin_w[1];
            out_allowin = ~out_allowin;
            ready_go    = ~ready_go;
            #1;
            chk("allowin_comb_path[d2]", 32'(in_allowin_w[1]), 32'(a_allow));
            out_allowin = ~out_allowin;
            ready_go    = ~ready_go;
            #1;
        end
    end

    initial begin
        bit accepted;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; ready_go = 1'b1;
        out_allowin = 1'b0; flush = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset mid-stream with the skid buffer full
        in_valid = 1'b1; in_data = 32'h0000_000A; tick();
        in_data = 32'h0000_000B; tick();
        in_valid = 1'b0; tick();
        rst = 1'b1; tick();
        rst = 1'b0; tick();

        // Streaming 1..100 with no backpressure
        out_allowin = 1'b1; ready_go = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            in_valid = 1'b1; in_data = 32'(k); tick();
        end
        in_valid = 1'b0; repeat (3) tick();

        // Backpressure: 0x11, 0x22, 0x33 while downstream blocked
        out_allowin = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; tick();
        in_data = 32'h22; tick();
        in_data = 32'h33; repeat (3) tick();
        out_allowin = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (!accepted) begin
                if (in_allowin_w[1]) accepted = 1'b1;
                tick();
            end
        end
        if (!accepted) chk("backpressure_accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0; repeat (4) tick();

        // Stall: hold 0x1234 with ready_go low for 5 cycles
        flush = 1'b1; tick();
        flush = 1'b0; out_allowin = 1'b0; ready_go = 1'b1;
        in_valid = 1'b1; in_data = 32'h1234; tick();
        in_valid = 1'b0; ready_go = 1'b0; out_allowin = 1'b1;
        repeat (5) tick();
        ready_go = 1'b1; repeat (2) tick();

        // Flush collides with push and pop in the same cycle
        flush = 1'b1; tick();
        flush = 1'b0; out_allowin = 1'b0;
        in_valid = 1'b1; in_data = 32'hAA; tick();
        in_data = 32'hBB; out_allowin = 1'b1; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0; repeat (3) tick();

        // Random handshake traffic
        for (int k = 0; k < 10000; k++) begin
            in_valid    = 1'($urandom_range(1, 0));
            out_allowin = 1'($urandom_range(1, 0));
            ready_go    = 1'($urandom_range(1, 0));
            in_data     = $urandom;
            tick();
        end
        in_valid = 1'b0; out_allowin = 1'b1; ready_go = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register for the 5-stage CPU. Replaces the per-stage hand-written registers (IF/ID, ID/EX, ...) with one generic block.
- Handshake: valid/allowin, with a stage ready_go qualifier and a synchronous flush.
- Adds a selectable depth:
  - DEPTH=1: classic single register.
  - DEPTH=2: skid buffer. Upstream allowin depends only on registered state, which breaks the combinational allowin chain.
- Payload is an opaque bus, packed by the instantiating stage.

Parameters:
- DATA_W, 64, payload width in bits (e.g. {pc[31:0], instr[31:0]}).
- DEPTH, 1, number of entries; legal values are 1 or 2 only. Any other value is an elaboration error.
- CLEAR_VAL, {DATA_W{1'b0}}, value driven on out_data after reset or flush.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream has a valid payload.
- in_allowin  out  1  this stage accepts a payload this cycle.
- in_data  in  DATA_W  upstream payload.
- ready_go  in  1  head entry may leave the stage (0 = stall, e.g. load-use).
- out_allowin  in  1  downstream accepts.
- out_valid  out  1  head entry valid and ready_go.
- out_data  out  DATA_W  head entry payload.
- flush  in  1  discard all entries (branch/exception redirect).
- occupancy  out  2  number of valid entries, 0..DEPTH.

Behaviour:
- Definitions:
  - push = in_valid & in_allowin & ~flush
  - pop = out_valid & out_allowin
  - head_valid = occupancy != 0
  - out_valid = head_valid & ready_go (combinational)
- Reset (rst=1 at posedge):
  - occupancy=0, out_data=CLEAR_VAL, all entry valid bits 0.
  - Resulting outputs: out_valid=0; in_allowin=1 in both depths.
- Flush (rst=0, flush=1 at posedge):
  - Same end state as reset, regardless of push or pop that cycle. Flush has priority over push and pop.
  - in_allowin is not gated by flush; the same-cycle upstream payload is dropped by the push definition.
- DEPTH=1:
  - in_allowin = ~head_valid | (ready_go & out_allowin). This is combinational, identical to the legacy stages.
  - push loads out_data<=in_data and sets valid. pop without push clears valid.
  - Latency in->out is 1 cycle. Throughput is 1/cycle.
- DEPTH=2:
  - in_allowin = (occupancy < 2), registered-only with no combinational path from out_allowin or ready_go.
  - Entries: head H and skid S. out_data = H.
  - State EMPTY (occ 0):
    - push: H<=in_data, go to ONE.
  - State ONE (occ 1):
    - push & pop: H<=in_data, stay in ONE.
    - push only: S<=in_data, go to FULL.
    - pop only: go to EMPTY; H retains its stale value.
    - neither: hold.
  - State FULL (occ 2, in_allowin=0):
    - pop: H<=S, go to ONE.
    - no pop: hold.
  - Ordering: strict FIFO, no reordering, no drops except on flush.
  - Latency: empty-to-out is 1 cycle. Throughput is 1/cycle sustained.
- ready_go=0 with head valid: out_valid=0, nothing pops, and data is held unchanged for any number of cycles.
- out_data when not valid: retains the last head value (CLEAR_VAL after reset or flush). Consumers must qualify it with out_valid.
- Payload is never modified. No arithmetic is performed on it.

Decomposition:
- Shared package cpu_pipe_pkg:
  - localparams PIPE_DEPTH_REG=1 and PIPE_DEPTH_SKID=2.
  - Per-stage payload width constants: IF_ID_W=64, ID_EX_W, EX_MEM_W, MEM_WB_W.
  - occupancy encodings OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2.
- One natural sub-module: pipe_skid_ctrl, the DEPTH=2 state machine. It produces H/S load enables and occupancy. It is instantiated in a generate branch only when DEPTH==2.

Test Plan:
- Reset mid-stream: DEPTH=2, fill to occ=2 with 0xA/0xB, assert rst one cycle -> occupancy=0, out_valid=0, out_data=0, in_allowin=1 next cycle.
- Streaming: DEPTH=1 and DEPTH=2, in_valid=1 with data 1,2,3,...,100, out_allowin=ready_go=1 -> out_data sequence 1..100 in order, one per cycle, first at cycle+1.
- Backpressure: DEPTH=2, send 0x11,0x22,0x33 while out_allowin=0 -> occupancy reaches 2 and in_allowin=0 after 0x22. Release out_allowin -> 0x11, 0x22, 0x33 delivered, no loss or duplicate.
- Stall: DEPTH=1 holding 0x1234, ready_go=0 for 5 cycles with out_allowin=1 -> out_valid=0 and out_data=0x1234 held. in_allowin=0 for all 5 cycles.
- Flush collision: DEPTH=2, occ=1 holding 0xAA, in_valid=1 with 0xBB, pop and flush all asserted in the same cycle -> occupancy=0, out_data=CLEAR_VAL, 0xBB never appears on the output.
- Random: in_valid, out_allowin, ready_go each random at 50% over 10k cycles, DEPTH=1 and DEPTH=2, scoreboarded -> output order equals input order, occupancy ≤ DEPTH always, and for DEPTH=2 in_allowin never depends combinationally on out_allowin.
